// File: rtl/wavelet_tap_sequencer.sv
// Sliding tap window and start strobe for the fir bank, plus capture and per-channel streaming of results.
// First result word is valid 3 cycles after a firing sample; o_ready is low from CALC until the last word transfers.
module wavelet_tap_sequencer #(
  parameter int BITS_PER_ELEM  = 8,
  parameter int NUM_ELEM       = 7,
  parameter int NUM_FILTERS    = 4,
  parameter int SUM_TRUNCATION = 8,
  parameter int DECIMATE       = 1,
  parameter int CH_BITS        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BITS_PER_ELEM-1:0]             i_sample,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0]    o_taps,
  output logic                                 o_start_calc,
  input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] i_wavelets,
  output logic [SUM_TRUNCATION-1:0]            o_data,
  output logic [CH_BITS-1:0]                   o_channel,
  output logic                                 o_last,
  output logic                                 o_valid,
  input  logic                                 i_ready
);

  localparam int FILL_W = $clog2(NUM_ELEM + 1);
  localparam int DEC_W  = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  typedef enum logic [1:0] {IDLE, CALC, CAPT, SEND} state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [NUM_ELEM*BITS_PER_ELEM-1:0]     r_taps;
  logic [FILL_W-1:0]                     r_fill;
  logic [DEC_W-1:0]                      r_dec;
  logic [CH_BITS-1:0]                    r_ch;
  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] r_buf;

  logic w_accept;
  logic w_full_next;
  logic w_fire;
  logic w_xfer;
  logic w_last_ch;

  assign w_accept    = i_valid && (r_state == IDLE);
  // The window counts as full when this sample completes it.
  assign w_full_next = (r_fill >= FILL_W'(NUM_ELEM - 1));
  assign w_fire      = w_accept && w_full_next && (r_dec == '0);
  assign w_xfer      = (r_state == SEND) && i_ready;
  assign w_last_ch   = (r_ch == CH_BITS'(NUM_FILTERS - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fire) w_state_nxt = CALC;
      CALC:    w_state_nxt = CAPT;
      CAPT:    w_state_nxt = SEND;
      SEND:    if (w_xfer && w_last_ch) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_taps <= '0;
      r_fill <= '0;
      r_dec  <= '0;
      r_ch   <= '0;
      r_buf  <= '0;
    end else begin
      if (w_accept) begin
        r_taps <= {r_taps[(NUM_ELEM-1)*BITS_PER_ELEM-1:0], i_sample};
        if (r_fill != FILL_W'(NUM_ELEM)) r_fill <= r_fill + 1'b1;
        if (w_full_next) r_dec <= (r_dec == DEC_W'(DECIMATE - 1)) ? '0 : r_dec + 1'b1;
      end
      if (r_state == CAPT) begin
        r_buf <= i_wavelets;
        r_ch  <= '0;
      end else if (w_xfer) begin
        r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
      end
    end
  end

  // Every output decodes registered state only; nothing flows through from i_valid or i_ready.
  assign o_ready      = (r_state == IDLE);
  assign o_start_calc = (r_state == CALC);
  assign o_valid      = (r_state == SEND);
  assign o_last       = (r_state == SEND) && w_last_ch;
  assign o_channel    = r_ch;
  assign o_data       = r_buf[r_ch*SUM_TRUNCATION +: SUM_TRUNCATION];
  assign o_taps       = r_taps;

endmodule

// File: tb/tb_wavelet_tap_sequencer.sv
// Bench for wavelet_tap_sequencer (DECIMATE=3): vector table of samples with expected strobes,
// result words scoreboarded in a queue and compared as the DUT streams them.
module tb_wavelet_tap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_sample;
  logic        i_valid;
  logic        o_ready;
  logic [55:0] o_taps;
  logic        o_start_calc;
  logic [31:0] i_wavelets;
  logic [7:0]  o_data;
  logic [1:0]  o_channel;
  logic        o_last;
  logic        o_valid;
  logic        i_ready;

  wavelet_tap_sequencer #(
    .BITS_PER_ELEM(8), .NUM_ELEM(7), .NUM_FILTERS(4), .SUM_TRUNCATION(8), .DECIMATE(3)
  ) dut (
    .clk(clk), .rst(rst), .i_sample(i_sample), .i_valid(i_valid), .o_ready(o_ready),
    .o_taps(o_taps), .o_start_calc(o_start_calc), .i_wavelets(i_wavelets),
    .o_data(o_data), .o_channel(o_channel), .o_last(o_last), .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sample;
    bit          fire;
    logic [31:0] wav;
    int          stall_ch;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] dat;
    bit         last;
  } word_t;

  vec_t        tbl[20];
  word_t       q[$];
  logic [55:0] m_taps;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] s, input bit f, input logic [31:0] w, input int st);
    vec_t v;
    v.sample = s; v.fire = f; v.wav = w; v.stall_ch = st;
    return v;
  endfunction

  task automatic drain(input int stall_ch);
    int          cyc = 0;
    bit          stalled = 0;
    word_t       e;
    logic [7:0]  sd;
    logic [1:0]  sc;
    while (q.size() > 0 && cyc < 40) begin
      chk("stream_valid", o_valid, 1);
      if (o_valid && o_channel == stall_ch && !stalled) begin
        stalled = 1;
        sd = o_data;
        sc = o_channel;
        i_ready = 1'b0;
        repeat (5) begin
          step();
          chk("bp_valid", o_valid, 1);
          chk("bp_data", o_data, sd);
          chk("bp_chan", o_channel, sc);
          chk("bp_ready", o_ready, 0);
          chk("bp_taps", o_taps, m_taps);
        end
        i_ready = 1'b1;
      end
      if (o_valid) begin
        e = q.pop_front();
        chk("word_chan", o_channel, e.ch);
        chk("word_data", o_data, e.dat);
        chk("word_last", o_last, e.last);
      end
      step();
      cyc++;
    end
    chk("stream_done", q.size(), 0);
    if (stall_ch < 0) chk("stream_cycles", cyc, 4);
    chk("post_ready", o_ready, 1);
    chk("post_valid", o_valid, 0);
    q.delete();
  endtask

  task automatic apply(input vec_t v);
    int    budget = 0;
    word_t w;
    while (!o_ready && budget < 50) begin
      step();
      budget++;
    end
    chk("ready_wait", budget < 50, 1);
    i_sample = v.sample;
    i_valid  = 1'b1;
    step();
    m_taps = {m_taps[47:0], v.sample};
    chk("strobe", o_start_calc, v.fire);
    chk("taps", o_taps, m_taps);
    chk("ready_after", o_ready, !v.fire);
    if (v.fire) begin
      // Offer a sample throughout the busy phase; it must not be consumed.
      i_sample   = 8'hA5;
      i_wavelets = v.wav;
      for (int k = 0; k < 4; k++) begin
        w.ch = 2'(k); w.dat = v.wav[k*8 +: 8]; w.last = (k == 3);
        q.push_back(w);
      end
      step();
      chk("strobe_once", o_start_calc, 0);
      chk("capt_valid", o_valid, 0);
      step();
      i_wavelets = 32'hDEADBEEF;
      chk("first_valid_lat3", o_valid, 1);
      drain(v.stall_ch);
      chk("busy_taps", o_taps, m_taps);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 6; i++) tbl[i] = mk(8'(i + 1), 0, 32'h0, -1);
    tbl[6] = mk(8'd7, 1, 32'h44332211, 1);
    tbl[7] = mk(8'd8, 0, 32'h0, -1);
    tbl[8] = mk(8'd9, 0, 32'h0, -1);
    for (int i = 0; i < 9; i++)
      tbl[9 + i] = mk(8'(10 + i), (i % 3) == 0, 32'hA0B0C0D0 + 32'(i), -1);
    tbl[18] = mk(8'h80, 1, 32'h7F01FE80, -1);
    tbl[19] = mk(8'hFF, 0, 32'h0, -1);

    rst = 1'b0; i_valid = 1'b0; i_sample = 8'h0; i_ready = 1'b1; i_wavelets = 32'h0;
    m_taps = '0;
    step(); step();
    rst = 1'b1;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_strobe", o_start_calc, 0);
    chk("rst_taps", o_taps, 0);
    chk("rst_data", o_data, 0);
    chk("rst_chan", o_channel, 0);
    chk("rst_last", o_last, 0);

    for (int i = 0; i < 20; i++) apply(tbl[i]);
    chk("neg_elem0", o_taps[7:0], 8'hFF);
    chk("neg_elem1", o_taps[15:8], 8'h80);
    chk("fill_elem6", o_taps[55:48], 8'd14);

    // Reset while the stream sits on channel 1.
    apply(mk(8'h01, 0, 32'h0, -1));
    i_sample = 8'h02; i_valid = 1'b1;
    step();
    m_taps = {m_taps[47:0], 8'h02};
    chk("mid_strobe", o_start_calc, 1);
    i_valid = 1'b0;
    i_wavelets = 32'h0C0B0A09;
    step(); step();
    chk("mid_valid", o_valid, 1);
    chk("mid_ch0", o_channel, 0);
    step();
    chk("mid_ch1", o_channel, 1);
    chk("mid_data1", o_data, 8'h0A);
    i_valid = 1'b1; i_sample = 8'h55; rst = 1'b0;
    step();
    rst = 1'b1; i_valid = 1'b0;
    m_taps = '0;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_taps", o_taps, 0);
    chk("mrst_ready", o_ready, 1);
    chk("mrst_chan", o_channel, 0);
    chk("mrst_data", o_data, 0);
    chk("mrst_last", o_last, 0);
    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      v.stall_ch = -1;
      apply(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
